// File: rtl/ps2_pkg.sv
// Shared PS/2 scan codes, key bitmap indices, receiver states and the scan-code to key lookup.
// Purely declarative: no latency, no backpressure.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;

  localparam logic [1:0] KEY_LEFT   = 2'd0;
  localparam logic [1:0] KEY_RIGHT  = 2'd1;
  localparam logic [1:0] KEY_UP     = 2'd2;
  localparam logic [1:0] KEY_ACTION = 2'd3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } key_hit_t;

  // Extended and plain codes that alias the same game key map to one bit.
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = KEY_LEFT;
    case ({ext, code})
      {1'b0, SC_A},     {1'b1, SC_LEFT}:  r.idx = KEY_LEFT;
      {1'b0, SC_D},     {1'b1, SC_RIGHT}: r.idx = KEY_RIGHT;
      {1'b0, SC_W},     {1'b1, SC_UP}:    r.idx = KEY_UP;
      {1'b0, SC_SPACE}:                   r.idx = KEY_ACTION;
      default:                            r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pad sync, falling-edge detect, 11-bit frame FSM with mid-frame timeout.
// Result/error registered 1 clk after the stop-bit edge cycle; no backpressure (pulses are not held).
module ps2_rx #(
  parameter int TIMEOUT_CYC = 65000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_dat_o,
  output logic       frame_err_o
);
  import ps2_pkg::*;

  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_prev_q;
  logic          fall;
  logic          dat;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          vld_q, vld_d;
  logic [7:0]    dat_q, dat_d;
  logic          err_q, err_d;

  // Sync flops reset to the idle-high bus level so reset release never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign dat  = dat_sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      vld_q     <= 1'b0;
      dat_q     <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    vld_d     = 1'b0;
    dat_d     = dat_q;
    err_d     = 1'b0;
    tmo_d     = (state_q == RX_IDLE || fall) ? '0 : tmo_q + TW'(1);

    case (state_q)
      RX_IDLE: begin
        if (fall && !dat) begin
          state_d   = RX_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          parity_d = dat;
          state_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_d = RX_IDLE;
          if (dat && ^{shift_q, parity_q}) begin
            vld_d = 1'b1;
            dat_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // A keyboard that stops clocking mid-frame abandons the partial byte.
    if (state_q != RX_IDLE && !fall && tmo_d == TMO_LAST) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
      vld_d   = 1'b0;
    end
  end

  assign byte_vld_o  = vld_q;
  assign byte_dat_o  = dat_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receives frames, tracks E0/F0 prefixes and keeps the held-key bitmap.
// key updates 1 clk after byte_valid; no backpressure, every received byte is decoded.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYC = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  import ps2_pkg::*;

  logic       rx_vld;
  logic [7:0] rx_dat;
  logic       rx_err;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [3:0] key_q, key_d;
  key_hit_t   hit;

  ps2_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk_i       (clk),
    .rst_i       (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_data),
    .byte_vld_o  (rx_vld),
    .byte_dat_o  (rx_dat),
    .frame_err_o (rx_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      key_q <= 4'b0000;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      key_q <= key_d;
    end
  end

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    key_d = key_q;
    hit   = key_lookup(ext_q, rx_dat);

    // A damaged frame may have been a prefix, so forget any pending prefix state.
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_vld) begin
      if (rx_dat == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_dat == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (hit.hit) key_d[hit.idx] = ~brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign key        = key_q;
  assign byte_valid = rx_vld;
  assign byte_data  = rx_dat;
  assign frame_err  = rx_err;

endmodule
